uc_multiciclo: RTL

Multi-cycle control unit for the 8-bit microcontroller datapath. It decodes the 6-bit opcode and the registered zero flag into the datapath control lines (`s_inc`, `s_inm`, `we`, `wez`, `alu_op`) plus the PC and instruction-register enables. Every instruction runs as a FETCH/EXEC pair, with an optional single-step debug mode and a halt state. It sits beside the datapath inside the top-level CPU and is the only block that drives its control inputs.

---
 rtl/uc_multiciclo.sv | 76 +++++++
 1 files changed

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle control unit (FETCH/EXEC with single-step wait and halt) plus retired-instruction counter
module uc_multiciclo #(
  parameter logic RESET_PC_EN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        step_mode,
  input  logic        step,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we,
  output logic        wez,
  output logic [2:0]  alu_op,
  output logic        pc_en,
  output logic        ir_en,
  output logic        halted,
  output logic [15:0] instret
);
  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_instret;
  logic        w_halt_op;
  assign w_halt_op = opcode == 6'h3f;
  assign instret   = r_instret;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == EXEC && !w_halt_op) r_instret <= r_instret + 16'd1;
    end
  end
  always_comb begin
    w_next = r_state;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we     = 1'b0;
    wez    = 1'b0;
    alu_op = 3'b000;
    pc_en  = 1'b0;
    ir_en  = 1'b0;
    halted = 1'b0;
    case (r_state)
      FETCH: begin
        ir_en  = 1'b1;
        pc_en  = RESET_PC_EN;
        w_next = (step_mode && !step) ? WAIT : EXEC;
      end
      WAIT: w_next = (step || !step_mode) ? EXEC : WAIT;
      EXEC: begin
        pc_en  = !w_halt_op;
        w_next = w_halt_op ? HALT : FETCH;
        casez (opcode)
          6'b00????: begin
            alu_op = opcode[2:0];
            we     = 1'b1;
            wez    = 1'b1;
          end
          6'b01????: begin
            s_inm = 1'b1;
            we    = 1'b1;
          end
          6'b100000: s_inc = 1'b0;
          6'b100001: s_inc = ~zero;
          6'b100010: s_inc = zero;
          default: ;
        endcase
      end
      HALT: halted = 1'b1;
      default: w_next = FETCH;
    endcase
  end
endmodule
